// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit teaching CPU datapath.
//   DATA_W   : register width
//   OP_W     : opcode width
//   opcode_e : opcode encodings OP_NOP..OP_DEC
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_RCL  = 4'd10,
    OP_RCR  = 4'd11,
    OP_MOV  = 4'd12,
    OP_SWAP = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } opcode_e;

endpackage

// File: rtl/cpu_alu.sv
// ALU for the teaching CPU: computes the next A value and next carry.
// Ports:
//   op      in  opcode
//   a, b    in  operands (registers A and B)
//   carryin in  current carry flag
//   result  out next A value (A itself for routing-only opcodes)
//   carry   out next carry flag (carryin for routing-only opcodes)
import cpu_pkg::*;

module cpu_alu (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carryin,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // 9-bit intermediate: bit 8 is carry out, or borrow for subtraction
  logic [DATA_W:0] wide;

  always_comb begin
    wide = {carryin, a};
    case (op)
      OP_NOP,
      OP_MOV,
      OP_SWAP: wide = {carryin, a};
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_ADC:  wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carryin};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_SHL:  wide = {a[7], a[6:0], 1'b0};
      OP_SHR:  wide = {a[0], 1'b0, a[7:1]};
      OP_RCL:  wide = {a[7], a[6:0], carryin};
      OP_RCR:  wide = {a[0], carryin, a[7:1]};
      OP_INC:  wide = {1'b0, a} + 9'd1;
      OP_DEC:  wide = {1'b0, a} - 9'd1;
      // unknown opcode bits yield unknown results instead of masking to NOP
      default: wide = 'x;
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign carry  = wide[DATA_W];

endmodule

// File: rtl/cpu_comb.sv
// Combinational next-state datapath of the 8-bit teaching CPU.
// The external register file captures the outputs each clock; this block
// holds no state, so clk and reset are accepted but unused.
// Ports:
//   clk, reset          in  unused (interface compatibility)
//   op                  in  4-bit opcode
//   Ain/Bin/Cin/Din     in  current registers
//   Carryin             in  current carry flag
//   Aout/Bout/Cout/Dout out next registers
//   Carryout            out next carry flag
import cpu_pkg::*;

module cpu_comb (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  input  logic [DATA_W-1:0] Cin,
  input  logic [DATA_W-1:0] Din,
  input  logic              Carryin,
  output logic [DATA_W-1:0] Aout,
  output logic [DATA_W-1:0] Bout,
  output logic [DATA_W-1:0] Cout,
  output logic [DATA_W-1:0] Dout,
  output logic              Carryout
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              unused_clk_reset;

  assign unused_clk_reset = ^{clk, reset};

  cpu_alu u_alu (
    .op      (op),
    .a       (Ain),
    .b       (Bin),
    .carryin (Carryin),
    .result  (alu_result),
    .carry   (alu_carry)
  );

  always_comb begin
    Aout     = alu_result;
    Bout     = Bin;
    Cout     = Cin;
    Dout     = Din;
    Carryout = alu_carry;
    case (op)
      OP_MOV:  Aout = Bin;
      OP_SWAP: begin
        Aout = Bin;
        Bout = Ain;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_comb.sv
// Directed self-checking bench for cpu_comb.
module tb_cpu_comb;

  logic       clk;
  logic       reset;
  logic [3:0] op;
  logic [7:0] a_in, b_in, c_in, d_in;
  logic       carry_in;
  logic [7:0] a_out, b_out, c_out, d_out;
  logic       carry_out;

  int unsigned n_checks;
  int unsigned n_pass;

  cpu_comb dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .Ain      (a_in),
    .Bin      (b_in),
    .Cin      (c_in),
    .Din      (d_in),
    .Carryin  (carry_in),
    .Aout     (a_out),
    .Bout     (b_out),
    .Cout     (c_out),
    .Dout     (d_out),
    .Carryout (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Apply inputs mid-cycle, let them settle, then sample
  task automatic apply(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    @(negedge clk);
    op = o; a_in = a; b_in = b; carry_in = ci;
    #1;
  endtask

  logic [7:0] exp_a  [0:13] = '{8'hCC, 8'h21, 8'h77, 8'h22, 8'h44, 8'hDD, 8'h99,
                                8'h33, 8'h98, 8'h66, 8'h99, 8'hE6, 8'h55, 8'h55};
  logic       exp_co [0:13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    op       = '0;
    a_in     = '0;
    b_in     = '0;
    c_in     = 8'h0F;
    d_in     = 8'hF0;
    carry_in = 1'b0;

    // Table sweep over op 0..13
    for (int i = 0; i < 14; i++) begin
      apply(4'(i), 8'hCC, 8'h55, 1'b1);
      check($sformatf("tbl_op%0d_A", i), a_out, exp_a[i]);
      check($sformatf("tbl_op%0d_Co", i), {7'd0, carry_out}, {7'd0, exp_co[i]});
      check($sformatf("tbl_op%0d_C", i), c_out, 8'h0F);
      check($sformatf("tbl_op%0d_D", i), d_out, 8'hF0);
      check($sformatf("tbl_op%0d_B", i), b_out, (i == 13) ? 8'hCC : 8'h55);
    end

    // INC / DEC simple
    apply(4'd14, 8'h01, 8'h00, 1'b0);
    check("inc_A", a_out, 8'h02);
    check("inc_Co", {7'd0, carry_out}, 8'h00);
    apply(4'd15, 8'h02, 8'h00, 1'b0);
    check("dec_A", a_out, 8'h01);
    check("dec_Co", {7'd0, carry_out}, 8'h00);

    // Small arithmetic A=8, B=6
    apply(4'd1, 8'h08, 8'h06, 1'b0);
    check("add_small_A", a_out, 8'h0E);
    check("add_small_Co", {7'd0, carry_out}, 8'h00);
    apply(4'd2, 8'h08, 8'h06, 1'b0);
    check("sub_small_A", a_out, 8'h02);
    check("sub_small_Co", {7'd0, carry_out}, 8'h00);
    apply(4'd3, 8'h08, 8'h06, 1'b1);
    check("adc_small_A", a_out, 8'h0F);
    check("adc_small_Co", {7'd0, carry_out}, 8'h00);

    // Wrap and borrow
    apply(4'd14, 8'hFF, 8'h00, 1'b0);
    check("inc_wrap_A", a_out, 8'h00);
    check("inc_wrap_Co", {7'd0, carry_out}, 8'h01);
    apply(4'd15, 8'h00, 8'h00, 1'b0);
    check("dec_wrap_A", a_out, 8'hFF);
    check("dec_wrap_Co", {7'd0, carry_out}, 8'h01);
    apply(4'd2, 8'h06, 8'h08, 1'b0);
    check("sub_borrow_A", a_out, 8'hFE);
    check("sub_borrow_Co", {7'd0, carry_out}, 8'h01);
    apply(4'd1, 8'hFF, 8'h01, 1'b0);
    check("add_wrap_A", a_out, 8'h00);
    check("add_wrap_Co", {7'd0, carry_out}, 8'h01);

    // Carry passthrough on NOP with Carryin=0
    apply(4'd0, 8'h5A, 8'hA5, 1'b0);
    check("nop_c0_A", a_out, 8'h5A);
    check("nop_c0_Co", {7'd0, carry_out}, 8'h00);

    // Reset independence: outputs follow inputs across clock edges
    reset = 1'b1;
    apply(4'd1, 8'h08, 8'h06, 1'b0);
    check("rst_add_A", a_out, 8'h0E);
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_A", a_out, 8'h0E);
    check("rst_clk_Co", {7'd0, carry_out}, 8'h00);
    reset = 1'b0;
    #1;
    check("rst_rel_A", a_out, 8'h0E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
